// File: rtl/mem_arb_pkg.sv
// Shared encodings and memory-map constants for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_M    = 2'd3
    } owner_t;

    localparam int unsigned MEM_WORDS = 512;
    localparam int unsigned MON_BASE  = 495;
    localparam int unsigned MON_LAST  = 510;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational requester picker: D > I > M, unless the monitor has starved.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic             m_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output owner_t           owner
);

    always_comb begin
        owner = OWN_NONE;
        if (m_req && (32'(starve_cnt) >= STARVE_LIMIT)) begin
            owner = OWN_M;
        end else if (d_req) begin
            owner = OWN_D;
        end else if (i_req) begin
            owner = OWN_I;
        end else if (m_req) begin
            owner = OWN_M;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-fetch, load/store and monitor reads onto one single-port memory.
// Three-phase handshake per access: IDLE (grant) -> ACCESS (drive) -> RESP (ack).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned MEM_WORDS    = mem_arb_pkg::MEM_WORDS,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    input  logic              m_req,
    input  logic [ADDR_W-1:0] m_addr,
    output logic              m_ack,
    output logic [31:0]       m_rdata,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    state_t            state, state_n;
    owner_t            owner, pick;
    logic              we_q, in_range_q;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_in_range;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_prio (
        .i_req      (i_req),
        .d_req      (d_req),
        .m_req      (m_req),
        .starve_cnt (starve_cnt),
        .owner      (pick)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        case (pick)
            OWN_I: sel_addr = i_addr;
            OWN_D: begin
                sel_addr  = d_addr;
                sel_wdata = d_wdata;
            end
            OWN_M: sel_addr = m_addr;
            default: ;
        endcase
        sel_in_range = 32'(sel_addr) < MEM_WORDS;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick != OWN_NONE) state_n = ACCESS;
            ACCESS:  state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Gated by reset combinationally so a store caught mid-ACCESS never reaches the array.
    assign mem_write = (state == ACCESS) && we_q && in_range_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner          <= OWN_NONE;
            we_q           <= 1'b0;
            in_range_q     <= 1'b0;
            starve_cnt     <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            i_ack          <= 1'b0;
            d_ack          <= 1'b0;
            d_err          <= 1'b0;
            m_ack          <= 1'b0;
            i_rdata        <= '0;
            d_rdata        <= '0;
            m_rdata        <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            m_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!m_req || pick == OWN_M) begin
                        starve_cnt <= '0;
                    end else if ((pick == OWN_D || pick == OWN_I) &&
                                 (32'(starve_cnt) < STARVE_LIMIT)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                    if (pick != OWN_NONE) begin
                        owner          <= pick;
                        we_q           <= (pick == OWN_D) && d_we;
                        in_range_q     <= sel_in_range;
                        mem_addr       <= 32'(sel_addr);
                        mem_write_data <= sel_wdata;
                    end
                end
                ACCESS: begin
                    case (owner)
                        OWN_I: begin
                            i_ack   <= 1'b1;
                            i_rdata <= in_range_q ? mem_read_data : '0;
                        end
                        OWN_D: begin
                            d_ack <= 1'b1;
                            d_err <= !in_range_q;
                            if (!in_range_q)  d_rdata <= '0;
                            else if (!we_q)   d_rdata <= mem_read_data;
                        end
                        OWN_M: begin
                            m_ack   <= 1'b1;
                            m_rdata <= in_range_q ? mem_read_data : '0;
                        end
                        default: ;
                    endcase
                end
                RESP: begin
                    owner <= OWN_NONE;
                    we_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 512-word memory attached.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_req = 1'b0;
    logic [8:0]  i_addr = '0, d_addr = '0, m_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        i_ack, d_ack, d_err, m_ack, mem_write;
    logic [31:0] i_rdata, d_rdata, m_rdata, mem_addr, mem_write_data, mem_read_data;

    logic [31:0] mem [512];
    int          wr_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          ord [8];
    int          at [8];
    int          n, cyc, max_acks, acks, st4, st_m, wr_before;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (9),
        .MEM_WORDS    (500),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_ack          (i_ack),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ack          (d_ack),
        .d_err          (d_err),
        .d_rdata        (d_rdata),
        .m_req          (m_req),
        .m_addr         (m_addr),
        .m_ack          (m_ack),
        .m_rdata        (m_rdata),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_addr[8:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 512; k++) mem[k] <= '0;
            mem[128] <= 32'h8c030000;
            mem[10]  <= 32'h1111000A;
            mem[20]  <= 32'h22220014;
            mem[495] <= 32'hCAFE0495;
            mem[511] <= 32'h5A5A5A5A;
            mem[40]  <= 32'h40404040;
        end else if (mem_write) begin
            mem[mem_addr[8:0]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        reset = 1'b0; preload = 1'b0;
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_acks", {28'd0, i_ack, d_ack, d_err, m_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_rdata", i_rdata | d_rdata | m_rdata, 32'd0);
        chk("rst_starve", 32'(dut.starve_cnt), 32'd0);

        // Instruction fetch, exact latency
        i_req = 1'b1; i_addr = 9'd128;
        step();
        chk("i_access_addr", mem_addr, 32'd128);
        chk("i_access_noack", 32'(i_ack), 32'd0);
        step();
        chk("i_ack", 32'(i_ack), 32'd1);
        chk("i_rdata", i_rdata, 32'h8c030000);
        i_req = 1'b0;
        step();
        chk("i_ack_pulse", 32'(i_ack), 32'd0);
        chk("i_rdata_hold", i_rdata, 32'h8c030000);
        chk("i_no_write", 32'(wr_cnt), 32'd0);

        // Store then load at address 6
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'd6; d_wdata = 32'd7;
        step();
        chk("st_mem_write", 32'(mem_write), 32'd1);
        chk("st_mem_addr", mem_addr, 32'd6);
        chk("st_mem_wdata", mem_write_data, 32'd7);
        step();
        chk("st_ack", {30'd0, d_ack, d_err}, 32'd2);
        chk("st_write_drop", 32'(mem_write), 32'd0);
        chk("st_rdata_kept", d_rdata, 32'd0);
        d_req = 1'b0;
        step();
        chk("st_one_write", 32'(wr_cnt), 32'd1);
        chk("st_mem6", mem[6], 32'd7);
        d_req = 1'b1; d_we = 1'b0;
        step(); step();
        chk("ld_ack", 32'(d_ack), 32'd1);
        chk("ld_rdata", d_rdata, 32'd7);
        d_req = 1'b0;
        step();

        // Three simultaneous requesters, each dropping after its ack
        d_addr = 9'd10; i_addr = 9'd20; m_addr = 9'(MON_BASE);
        d_req = 1'b1; i_req = 1'b1; m_req = 1'b1;
        n = 0; max_acks = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            acks = int'(i_ack) + int'(d_ack) + int'(m_ack);
            if (acks > max_acks) max_acks = acks;
            if (d_ack && n < 8) begin ord[n] = int'(OWN_D); at[n] = c; n++; d_req = 1'b0; st4 = int'(dut.starve_cnt); end
            if (i_ack && n < 8) begin ord[n] = int'(OWN_I); at[n] = c; n++; i_req = 1'b0; st_m = int'(dut.starve_cnt); end
            if (m_ack && n < 8) begin ord[n] = int'(OWN_M); at[n] = c; n++; m_req = 1'b0; end
        end
        chk("tri_count", 32'(n), 32'd3);
        chk("tri_no_overlap", 32'(max_acks), 32'd1);
        chk("tri_first_D", 32'(ord[0]), 32'(OWN_D));
        chk("tri_second_I", 32'(ord[1]), 32'(OWN_I));
        chk("tri_third_M", 32'(ord[2]), 32'(OWN_M));
        chk("tri_spacing", {8'(at[0]), 8'(at[1]), 8'(at[2])}, {8'd0, 8'd2, 8'd5, 8'd8});
        chk("tri_starve_after_D", 32'(st4), 32'd1);
        chk("tri_starve_after_I", 32'(st_m), 32'd2);
        chk("tri_d_rdata", d_rdata, 32'h1111000A);
        chk("tri_i_rdata", i_rdata, 32'h22220014);
        chk("tri_m_rdata", m_rdata, 32'hCAFE0495);
        chk("tri_starve_clr", 32'(dut.starve_cnt), 32'd0);

        // Starvation: D and I held, M forced in after four D grants
        d_req = 1'b1; i_req = 1'b1; m_req = 1'b1;
        n = 0; st4 = -1; st_m = -1;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (d_ack && n < 8) begin
                ord[n] = int'(OWN_D); at[n] = c; n++;
                if (n == 4) st4 = int'(dut.starve_cnt);
            end
            if (i_ack && n < 8) begin ord[n] = int'(OWN_I); at[n] = c; n++; end
            if (m_ack && n < 8) begin
                ord[n] = int'(OWN_M); at[n] = c; n++; m_req = 1'b0;
                st_m = int'(dut.starve_cnt);
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        chk("stv_count", 32'(n), 32'd6);
        chk("stv_D_x4", {8'(ord[0]), 8'(ord[1]), 8'(ord[2]), 8'(ord[3])},
            {8'(OWN_D), 8'(OWN_D), 8'(OWN_D), 8'(OWN_D)});
        chk("stv_M_fifth", 32'(ord[4]), 32'(OWN_M));
        chk("stv_M_time", 32'(at[4]), 32'd14);
        chk("stv_D_sixth", 32'(ord[5]), 32'(OWN_D));
        chk("stv_cnt_sat", 32'(st4), 32'd4);
        chk("stv_cnt_clr", 32'(st_m), 32'd0);
        step(); step();

        // Out-of-range store with MEM_WORDS=500
        wr_before = wr_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h1FF; d_wdata = 32'hDEADBEEF;
        step();
        chk("oor_no_write", 32'(mem_write), 32'd0);
        chk("oor_addr", mem_addr, 32'h1FF);
        step();
        chk("oor_ack_err", {30'd0, d_ack, d_err}, 32'd3);
        chk("oor_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        step();
        chk("oor_err_pulse", 32'(d_err), 32'd0);
        chk("oor_mem_intact", mem[511], 32'h5A5A5A5A);
        chk("oor_wr_cnt", 32'(wr_cnt), 32'(wr_before));

        // Reset during the ACCESS of a store
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'd40; d_wdata = 32'h77;
        step();
        chk("rmid_write_on", 32'(mem_write), 32'd1);
        reset = 1'b1;
        step();
        chk("rmid_write_off", 32'(mem_write), 32'd0);
        chk("rmid_state", 32'(dut.state), 32'(IDLE));
        chk("rmid_no_ack", 32'(d_ack), 32'd0);
        chk("rmid_rdata", i_rdata | d_rdata | m_rdata, 32'd0);
        reset = 1'b0; d_req = 1'b0;
        step();
        chk("rmid_no_ack_later", 32'(d_ack), 32'd0);
        chk("rmid_mem40", mem[40], 32'h40404040);
        chk("rmid_wr_cnt", 32'(wr_cnt), 32'(wr_before));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port unified 512-word memory between three requesters:
  - instruction fetch (I),
  - load/store data (D),
  - monitor/display scanner (M, read-only).
- Sits between the CPU control path and the memory block. It owns that block's addr, write_data, MemWrite and read_data ports.
- Serialises accesses, one at a time. It guarantees MemWrite is never asserted except for a granted D write.

Parameters:
- ADDR_W, 9, word-address width of requester ports (512 words).
- MEM_WORDS, 512, number of valid words; addresses >= MEM_WORDS are out of range.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which M is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request, level, held until i_ack.
- i_addr  in  ADDR_W  fetch word address.
- i_ack  out  1  one-cycle pulse, i_rdata valid.
- i_rdata  out  32  fetched word, held until next I grant.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  pulse with d_ack when d_addr >= MEM_WORDS.
- d_rdata  out  32  load result, held.
- m_req  in  1  monitor read request.
- m_addr  in  ADDR_W  monitor word address.
- m_ack  out  1  one-cycle pulse.
- m_rdata  out  32  monitor word, held.
- mem_addr  out  32  to memory addr, zero-extended latched address.
- mem_write_data  out  32  to memory write_data.
- mem_write  out  1  to memory MemWrite.
- mem_read_data  in  32  from memory read_data; valid within the cycle addr is driven.

Behaviour:
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: drive memory.
  - RESP: pulse ack, no arbitration.
- Reset values:
  - state=IDLE, owner=none.
  - all ack/err = 0, mem_write = 0, mem_addr = 0, mem_write_data = 0.
  - i_rdata, d_rdata, m_rdata = 0.
  - starve_cnt = 0.
- IDLE:
  - If any req is high, latch owner, address, we and wdata into registers, then go to ACCESS.
  - Otherwise stay in IDLE.
- Priority: D > I > M.
  - Exception: if starve_cnt >= STARVE_LIMIT and m_req is high, M wins.
- Starvation counter:
  - starve_cnt increments on each grant to D or I while m_req is high (saturating at STARVE_LIMIT).
  - It clears on an M grant, or on any IDLE cycle with m_req low.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched address, zero-extended.
  - mem_write_data = latched wdata.
  - mem_write = 1 only if owner is D, we = 1 and the address is in range; otherwise 0.
  - At the closing edge, capture mem_read_data into the owner's rdata register.
    - Capture happens for reads only; a D store leaves d_rdata unchanged.
  - Out-of-range D access:
    - mem_write stays 0 and d_rdata is loaded with 0.
    - d_err pulses together with d_ack.
  - Out-of-range I/M addresses cannot occur, since ADDR_W=9 with MEM_WORDS=512. If parameters differ, the same rule applies but the read returns 0 and there is no err.
- RESP (1 cycle):
  - Owner's ack = 1; next state is IDLE.
  - The requester drops or changes req at the edge ending RESP.
  - If req is still high in IDLE, it is treated as a new request.
- Timing:
  - Latency: req sampled high in IDLE at cycle t → ACCESS at t+1 → ack at t+2 (rdata valid same cycle).
  - Throughput: one access per 3 cycles.
- Outside ACCESS, mem_write = 0 and mem_addr/mem_write_data hold their last value.
- Requester inputs are ignored outside IDLE; changes during ACCESS/RESP do not affect the in-flight access.
- Simultaneous requests: exactly one grant per IDLE decision; losers keep req high and are served in later rounds.
- Reset mid-operation: at the reset edge:
  - state goes to IDLE and mem_write drops to 0 (a pending store is aborted).
  - no ack is issued.
  - rdata registers go to 0.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2),
  - owner encoding (OWN_NONE, OWN_I, OWN_D, OWN_M),
  - MEM_WORDS and the monitor window constants (MON_BASE=495, MON_LAST=510).
- One natural sub-module, mem_arb_prio: a combinational priority picker taking the three reqs, starve_cnt and STARVE_LIMIT, and returning the owner code.
- The FSM, latches and ack/rdata registers stay in mem_arbiter.

Test Plan:
- Reset, then i_req=1, i_addr=128 with memory word 128 = 32'h8c030000 → mem_addr=128 at t+1, i_ack at t+2, i_rdata=32'h8c030000, mem_write never 1.
- d_req=1, d_we=1, d_addr=6, d_wdata=32'd7, then a load from address 6 → store: mem_write=1 for exactly one cycle, d_rdata unchanged. Load: d_rdata=7.
- i_req, d_req and m_req all raised together and held → grant order D, I, M. Each ack is 3 cycles apart; no overlapping acks.
- d_req and i_req held continuously with m_req=1 and STARVE_LIMIT=4 → M granted after 4 D/I grants; starve_cnt returns to 0.
- d_req=1, d_we=1, d_addr=9'h1FF with MEM_WORDS=500 → mem_write stays 0, d_err and d_ack pulse together, d_rdata=0.
- reset asserted during ACCESS of a D store → mem_write=0 from the next edge, no d_ack, state IDLE, memory word unchanged.
